ei_axi4_slave_mem: RTL and testbench

- AXI4 responder (slave-side RTL) with an internal word-addressed memory.
- Serves as the DUT endpoint that the VIP master driver targets. Also serves as a reference slave for loop-back benches.
- Independent write (AW/W/B) and read (AR/R) engines, one outstanding transaction per direction.
- Supports FIXED/INCR/WRAP bursts and narrow sizes; no IDs, no outstanding pipelining.

---
 rtl/ei_axi4_slave_pkg.sv | 29 ++
 rtl/ei_axi4_burst_addr_gen.sv | 60 ++++++
 rtl/ei_axi4_slave_mem.sv | 233 +++++++++++++++++++++++
 tb/tb_ei_axi4_slave_mem.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ei_axi4_slave_pkg.sv
// ----------------------------------------------------------------------------
// ei_axi4_slave_pkg
// Shared types for the AXI4 slave memory: burst encodings, response codes
// and the write/read engine state enumerations.
// ----------------------------------------------------------------------------
package ei_axi4_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// ei_axi4_burst_addr_gen
// Combinational burst address step plus legality/range check for one beat.
// Ports:
//   addr      - byte address of the current beat
//   len/size/burst - captured AXI burst attributes
//   next_addr - byte address of the following beat
//   word_idx  - memory word index of addr
//   in_range  - word index is below MEM_DEPTH
//   burst_err - size too large, reserved burst, or illegal WRAP length
// ----------------------------------------------------------------------------
module ei_axi4_burst_addr_gen
  import ei_axi4_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int MEM_AW     = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [MEM_AW-1:0]     word_idx,
  output logic                  in_range,
  output logic                  burst_err
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] container;
  logic [ADDR_WIDTH-1:0] lower;
  logic [ADDR_WIDTH-1:0] word_full;

  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    // INCR aligns to the beat size after the first beat
    incr_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    container = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    lower     = addr & ~(container - ADDR_WIDTH'(1));
    word_full = addr >> LSB;
    word_idx  = word_full[MEM_AW-1:0];
    in_range  = word_full < ADDR_WIDTH'(MEM_DEPTH);
    burst_err = size > 3'(LSB);
    next_addr = incr_addr;
    case (burst_e'(burst))
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP: begin
        next_addr = (incr_addr == lower + container) ? lower : incr_addr;
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) burst_err = 1'b1;
      end
      BURST_RSVD:  burst_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// ----------------------------------------------------------------------------
// ei_axi4_slave_mem
// AXI4 slave with an internal word-addressed memory. Independent write
// (AW/W/B) and read (AR/R) engines, one transaction in flight each.
// Ports:
//   aclk, aresetn          - clock, async active-low reset
//   aw*/w*/b*              - write address, data and response channels
//   ar*/r*                 - read address and data channels
// ----------------------------------------------------------------------------
module ei_axi4_slave_mem
  import ei_axi4_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  ready_en;

  wr_state_e             w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [MEM_AW-1:0]     w_word;
  logic                  w_in_range;
  logic                  w_burst_err;
  logic                  w_beat;
  logic                  w_last;

  rd_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ADDR_WIDTH-1:0] rg_addr;
  logic [7:0]            rg_len;
  logic [2:0]            rg_size;
  logic [1:0]            rg_burst;
  logic [ADDR_WIDTH-1:0] rg_next;
  logic [MEM_AW-1:0]     rg_word;
  logic                  rg_in_range;
  logic                  rg_burst_err;
  logic                  rg_ok;

  // Holds both address channels closed for the first cycle after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  assign awready = ready_en && (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bresp   = (bvalid && w_err) ? SLVERR : OKAY;
  assign w_beat  = wvalid && wready;
  assign w_last  = (w_cnt == w_len);

  ei_axi4_burst_addr_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .MEM_AW     (MEM_AW)
  ) u_wr_gen (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next),
    .word_idx  (w_word),
    .in_range  (w_in_range),
    .burst_err (w_burst_err)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            // Sticky: any bad beat or framing mismatch poisons the response
            if (w_burst_err || !w_in_range || (wlast != w_last)) w_err <= 1'b1;
            if (w_last) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane writes; memory contents deliberately survive reset
  always_ff @(posedge aclk) begin
    if (w_beat && !w_burst_err && w_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[w_word][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // In R_IDLE the generator looks at the AR channel so the first beat can be
  // loaded on the handshake; afterwards r_addr holds the next beat to load.
  assign rg_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
  assign rg_len   = (r_state == R_IDLE) ? arlen   : r_len;
  assign rg_size  = (r_state == R_IDLE) ? arsize  : r_size;
  assign rg_burst = (r_state == R_IDLE) ? arburst : r_burst;
  assign rg_ok    = !rg_burst_err && rg_in_range;
  assign arready  = ready_en && (r_state == R_IDLE);

  ei_axi4_burst_addr_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .MEM_AW     (MEM_AW)
  ) u_rd_gen (
    .addr      (rg_addr),
    .len       (rg_len),
    .size      (rg_size),
    .burst     (rg_burst),
    .next_addr (rg_next),
    .word_idx  (rg_word),
    .in_range  (rg_in_range),
    .burst_err (rg_burst_err)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_addr  <= rg_next;
            r_cnt   <= '0;
            rvalid  <= 1'b1;
            rdata   <= rg_ok ? mem[rg_word] : '0;
            rresp   <= rg_ok ? OKAY : SLVERR;
            rlast   <= (arlen == 8'd0);
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              rresp   <= OKAY;
              r_state <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_addr <= rg_next;
              rdata  <= rg_ok ? mem[rg_word] : '0;
              rresp  <= rg_ok ? OKAY : SLVERR;
              rlast  <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ei_axi4_slave_mem
// Directed bench for ei_axi4_slave_mem: a table of write/read bursts with
// hand-computed expectations, then hand-written sequences for narrow reads,
// concurrent engines and reset in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_ei_axi4_slave_mem;
  import ei_axi4_slave_pkg::*;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 64;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  ei_axi4_slave_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  typedef struct packed {
    logic             is_wr;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       strb;
    logic [7:0][31:0] data;
    logic [1:0]       resp;
    logic [7:0]       last_beat;
    logic [3:0]       stall_beat;
    logic [3:0]       stall_cycles;
  } vec_t;

  vec_t             vecs[$];
  logic [7:0][31:0] d_a;
  logic [7:0][31:0] d_b;

  // Safety net so a stuck handshake can never hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic is_wr, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] strb,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [1:0] resp, input int last_beat,
                              input int stall_beat, input int stall_cycles);
    vec_t v;
    v              = '0;
    v.is_wr        = is_wr;
    v.addr         = addr;
    v.len          = len;
    v.size         = size;
    v.burst        = burst;
    v.strb         = strb;
    v.data[0]      = d0;
    v.data[1]      = d1;
    v.data[2]      = d2;
    v.data[3]      = d3;
    v.resp         = resp;
    v.last_beat    = 8'(last_beat);
    v.stall_beat   = 4'(stall_beat);
    v.stall_cycles = 4'(stall_cycles);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: no handshake within %0d cycles, expected one", name, TIMEOUT);
  endtask

  // One complete write burst: AW, len+1 W beats, then B with optional delay
  task automatic writeBurst(input string name, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [7:0][31:0] data, input int last_beat, input int b_delay,
                            input logic [1:0] exp_resp);
    int n;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
    if (n >= TIMEOUT) begin reportTimeout({name, " aw"}); awvalid = 1'b0; return; end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = data[i]; wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
      if (n >= TIMEOUT) begin reportTimeout({name, " w"}); wvalid = 1'b0; wlast = 1'b0; return; end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
    if (n >= TIMEOUT) begin reportTimeout({name, " b"}); return; end
    for (int k = 0; k < b_delay; k++) begin
      @(negedge aclk);
      checkOutput($sformatf("%s bvalid held c%0d", name, k), 32'(bvalid), 32'd1);
      checkOutput($sformatf("%s awready stalled c%0d", name, k), 32'(awready), 32'd0);
    end
    checkOutput({name, " bresp"}, 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checkOutput({name, " bvalid clear"}, 32'(bvalid), 32'd0);
    checkOutput({name, " awready back"}, 32'(awready), 32'd1);
  endtask

  // One complete read burst, optionally holding rready low before one beat
  task automatic readBurst(input string name, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0][31:0] exp, input logic [1:0] exp_resp,
                           input int stall_beat, input int stall_cycles);
    int n;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
    if (n >= TIMEOUT) begin reportTimeout({name, " ar"}); arvalid = 1'b0; return; end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
      if (n >= TIMEOUT) begin reportTimeout({name, " r"}); rready = 1'b0; return; end
      if (i == stall_beat && stall_cycles > 0) begin
        rready = 1'b0;
        for (int k = 0; k < stall_cycles; k++) begin
          @(negedge aclk);
          checkOutput($sformatf("%s stall b%0d rdata c%0d", name, i, k), rdata, exp[i]);
          checkOutput($sformatf("%s stall b%0d rlast c%0d", name, i, k), 32'(rlast), 32'(i == int'(len)));
        end
      end
      checkOutput($sformatf("%s b%0d rdata", name, i), rdata, exp[i]);
      checkOutput($sformatf("%s b%0d rresp", name, i), 32'(rresp), 32'(exp_resp));
      checkOutput($sformatf("%s b%0d rlast", name, i), 32'(rlast), 32'(i == int'(len)));
      rready = 1'b1;
      @(negedge aclk);
    end
    rready = 1'b0;
    checkOutput({name, " rvalid clear"}, 32'(rvalid), 32'd0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string name;
    name = $sformatf("vec%0d", idx);
    if (v.is_wr)
      writeBurst(name, v.addr, v.len, v.size, v.burst, v.strb, v.data,
                 int'(v.last_beat), int'(v.stall_cycles), v.resp);
    else
      readBurst(name, v.addr, v.len, v.size, v.burst, v.data, v.resp,
                int'(v.stall_beat), int'(v.stall_cycles));
  endtask

  task automatic checkAllOutputsZero(input string name);
    checkOutput({name, " awready"}, 32'(awready), 32'd0);
    checkOutput({name, " wready"},  32'(wready),  32'd0);
    checkOutput({name, " bvalid"},  32'(bvalid),  32'd0);
    checkOutput({name, " bresp"},   32'(bresp),   32'd0);
    checkOutput({name, " arready"}, 32'(arready), 32'd0);
    checkOutput({name, " rvalid"},  32'(rvalid),  32'd0);
    checkOutput({name, " rdata"},   rdata,        32'd0);
    checkOutput({name, " rresp"},   32'(rresp),   32'd0);
    checkOutput({name, " rlast"},   32'(rlast),   32'd0);
  endtask

  initial begin
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state and the one-cycle ready hold-off after release
    repeat (3) @(negedge aclk);
    checkAllOutputsZero("in reset");
    aresetn = 1'b1;
    #1;
    checkOutput("first cycle awready", 32'(awready), 32'd0);
    checkOutput("first cycle arready", 32'(arready), 32'd0);
    @(negedge aclk);
    checkOutput("second cycle awready", 32'(awready), 32'd1);
    checkOutput("second cycle arready", 32'(arready), 32'd1);

    // Write = 1, read = 0; fields: addr len size burst strb d0..d3 resp last stall_beat stall_cycles
    vecs.push_back(mk(1, 32'h10,   3, 2, 2'b01, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, OKAY,   3, 0, 0));
    vecs.push_back(mk(0, 32'h10,   3, 2, 2'b01, 4'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, OKAY,   0, 2, 5));
    vecs.push_back(mk(1, 32'h30,   3, 2, 2'b01, 4'hF, 32'h1,  32'h2,  32'h3,  32'h4,  OKAY,   3, 0, 0));
    vecs.push_back(mk(0, 32'h38,   3, 2, 2'b10, 4'h0, 32'h3,  32'h4,  32'h1,  32'h2,  OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h0,    0, 2, 2'b01, 4'hF, 32'hFFFFFFFF, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h0,    0, 2, 2'b01, 4'h5, 32'h12345678, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(0, 32'h0,    0, 2, 2'b01, 4'h0, 32'hFF34FF78, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 0, 2, 2'b01, 4'hF, 32'hDEADBEEF, 0, 0, 0,        SLVERR, 0, 0, 0));
    vecs.push_back(mk(0, 32'h1000, 0, 2, 2'b01, 4'h0, 32'h0,  0, 0, 0,              SLVERR, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,    0, 2, 2'b01, 4'h0, 32'hFF34FF78, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(0, 32'h10,   1, 2, 2'b11, 4'h0, 32'h0,  32'h0,  0, 0,         SLVERR, 0, 0, 0));
    vecs.push_back(mk(1, 32'h20,   3, 2, 2'b01, 4'hF, 32'h20, 32'h21, 32'h22, 32'h23, SLVERR, 1, 0, 0));
    vecs.push_back(mk(1, 32'h50,   0, 2, 2'b01, 4'hF, 32'hCAFEF00D, 0, 0, 0,        OKAY,   0, 0, 3));
    vecs.push_back(mk(0, 32'h50,   0, 2, 2'b01, 4'h0, 32'hCAFEF00D, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h60,   2, 2, 2'b00, 4'hF, 32'h5,  32'h6,  32'h7,  0,    OKAY,   2, 0, 0));
    vecs.push_back(mk(0, 32'h60,   1, 2, 2'b00, 4'h0, 32'h7,  32'h7,  0, 0,         OKAY,   0, 0, 0));
    vecs.push_back(mk(0, 32'h20,   2, 2, 2'b10, 4'h0, 32'h0,  32'h0,  32'h0,  0,    SLVERR, 0, 0, 0));
    vecs.push_back(mk(1, 32'h70,   0, 2, 2'b01, 4'hF, 32'hDEAD0070, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h70,   0, 3, 2'b01, 4'hF, 32'h00000BAD, 0, 0, 0,        SLVERR, 0, 0, 0));
    vecs.push_back(mk(0, 32'h70,   0, 2, 2'b01, 4'h0, 32'hDEAD0070, 0, 0, 0,        OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h82,   1, 2, 2'b01, 4'hF, 32'h11110080, 32'h11110084, 0, 0, OKAY, 1, 0, 0));
    vecs.push_back(mk(0, 32'h80,   1, 2, 2'b01, 4'h0, 32'h11110080, 32'h11110084, 0, 0, OKAY, 0, 0, 0));
    vecs.push_back(mk(1, 32'h9C,   1, 2, 2'b10, 4'hF, 32'hB1, 32'hB2, 0, 0,         OKAY,   1, 0, 0));
    vecs.push_back(mk(0, 32'h98,   1, 2, 2'b01, 4'h0, 32'hB2, 32'hB1, 0, 0,         OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'h40,   1, 2, 2'b01, 4'hF, 32'h11111111, 32'h22222222, 0, 0, OKAY, 1, 0, 0));
    vecs.push_back(mk(1, 32'h10,   1, 2, 2'b11, 4'hF, 32'hBAD0, 32'hBAD1, 0, 0,     SLVERR, 1, 0, 0));
    vecs.push_back(mk(0, 32'h10,   0, 2, 2'b01, 4'h0, 32'hA0, 0, 0, 0,              OKAY,   0, 0, 0));
    vecs.push_back(mk(1, 32'hFFC,  1, 2, 2'b01, 4'hF, 32'hEEEE0001, 32'hEEEE0002, 0, 0, SLVERR, 1, 0, 0));
    vecs.push_back(mk(0, 32'hFFC,  0, 2, 2'b01, 4'h0, 32'hEEEE0001, 0, 0, 0,        OKAY,   0, 0, 0));

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Byte-sized INCR read stays on one word for four beats, then moves on
    d_a = '0;
    for (int i = 0; i < 4; i++) d_a[i] = 32'h11111111;
    for (int i = 4; i < 8; i++) d_a[i] = 32'h22222222;
    readBurst("narrow rd", 32'h40, 8'd7, 3'd0, 2'b01, d_a, OKAY, 0, 0);

    // Both engines busy at the same time
    d_a = '0; d_b = '0;
    d_a[0] = 32'hC0; d_a[1] = 32'hC1; d_a[2] = 32'hC2; d_a[3] = 32'hC3;
    d_b[0] = 32'h1;  d_b[1] = 32'h2;  d_b[2] = 32'h3;  d_b[3] = 32'h4;
    fork
      writeBurst("conc wr", 32'hA0, 8'd3, 3'd2, 2'b01, 4'hF, d_a, 3, 0, OKAY);
      readBurst("conc rd", 32'h30, 8'd3, 3'd2, 2'b01, d_b, OKAY, 0, 0);
    join
    readBurst("conc rdback", 32'hA0, 8'd3, 3'd2, 2'b01, d_a, OKAY, 0, 0);

    // Reset asserted during beat 2 of an 8-beat write
    awaddr = 32'hC0; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    checkOutput("rst seq awready", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    wdata = 32'h100; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    checkOutput("rst seq wready", 32'(wready), 32'd1);
    @(negedge aclk);
    wdata = 32'h101;
    #2;
    aresetn = 1'b0;
    #1;
    checkAllOutputsZero("mid-burst reset");
    wvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checkOutput("rst release awready", 32'(awready), 32'd0);
    checkOutput("rst release arready", 32'(arready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      checkOutput($sformatf("no bvalid after reset c%0d", k), 32'(bvalid), 32'd0);
    end
    checkOutput("rst recover awready", 32'(awready), 32'd1);
    d_a = '0; d_a[0] = 32'hA0;
    readBurst("post-reset rd", 32'h10, 8'd0, 3'd2, 2'b01, d_a, OKAY, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
